// File: rtl/vga_pkg.sv
// Shared timing defaults and game-state types for the 640x480@60 VGA timing generator.
package vga_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_CLK_DIV   = 2;
    localparam logic DEF_SYNC_POL = 1'b0;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Counters are 10 bits wide, so neither axis may exceed this many positions.
    localparam int MAX_TOTAL = 1024;

    typedef struct packed {
        logic [9:0] y;
        logic [9:0] x;
    } ball_t;

    typedef struct packed {
        logic [9:0] right;
        logic [9:0] left;
    } ppos_t;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } score_t;

    function automatic logic in_window(input logic [9:0] v, input int start, input int len);
        return (int'(v) >= start) && (int'(v) < start + len);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Renderer-side bundle: game-state offer/ack plus the raster scan and shadowed state.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic       upd_valid;
    ball_t      ball_in;
    score_t     score_in;
    ppos_t      ppos_in;
    logic       upd_ack;
    ball_t      ball;
    score_t     score;
    ppos_t      ppos;
    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic       pix_en;
    logic       hsync;
    logic       vsync;
    logic       visible;
    logic       frame_start;

    modport master (
        input  upd_valid, ball_in, score_in, ppos_in,
        output upd_ack, ball, score, ppos, hcnt, vcnt, pix_en,
               hsync, vsync, visible, frame_start
    );

    modport slave (
        output upd_valid, ball_in, score_in, ppos_in,
        input  upd_ack, ball, score, ppos, hcnt, vcnt, pix_en,
               hsync, vsync, visible, frame_start
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One scan axis: wrapping position counter with registered sync and visible flags
// that always describe the count currently presented.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int   TOTAL      = DEF_H_TOTAL,
    parameter int   SYNC_START = DEF_H_VISIBLE + DEF_H_FP,
    parameter int   SYNC_LEN   = DEF_H_SYNC,
    parameter int   VIS        = DEF_H_VISIBLE,
    parameter logic POL        = DEF_SYNC_POL
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [9:0] cnt,
    output logic       wrap,
    output logic       sync,
    output logic       vis
);

    logic [9:0] r_cnt;
    logic [9:0] w_cnt_next;
    logic       r_sync;
    logic       r_vis;

    assign wrap       = (r_cnt == 10'(TOTAL - 1));
    assign w_cnt_next = wrap ? 10'd0 : r_cnt + 10'd1;

    // Flags are computed from the next count so they land on the same edge as it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= 10'd0;
            r_sync <= ~POL;
            r_vis  <= 1'b1;
        end else if (en) begin
            r_cnt  <= w_cnt_next;
            r_sync <= in_window(w_cnt_next, SYNC_START, SYNC_LEN) ? POL : ~POL;
            r_vis  <= (int'(w_cnt_next) < VIS);
        end
    end

    assign cnt  = r_cnt;
    assign sync = r_sync;
    assign vis  = r_vis;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster source: pixel divider, h/v scan counters with sync, and a game-state
// shadow that reloads only at the start of vertical blanking.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_VISIBLE = DEF_H_VISIBLE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_VISIBLE = DEF_V_VISIBLE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter int   CLK_DIV   = DEF_CLK_DIV,
    parameter logic SYNC_POL  = DEF_SYNC_POL
)(
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master bus
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    generate
        if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed %0d", MAX_TOTAL);
        end
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be at least 1");
        end
    endgenerate

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_next;
    logic             r_pix_en;
    logic             r_frame_start;
    logic             r_upd_ack;
    ball_t            r_ball;
    score_t           r_score;
    ppos_t            r_ppos;

    logic [9:0] w_hcnt;
    logic [9:0] w_vcnt;
    logic       w_h_wrap;
    logic       w_v_wrap;
    logic       w_h_sync;
    logic       w_v_sync;
    logic       w_h_vis;
    logic       w_v_vis;
    logic       w_line_end;
    logic       w_capture;

    assign w_div_next = (r_div == DIV_W'(CLK_DIV - 1)) ? '0 : r_div + DIV_W'(1);

    // pix_en is registered from the next divider value, so it is low during reset
    // and then tracks div==CLK_DIV-1 (constantly high when CLK_DIV is 1).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div    <= '0;
            r_pix_en <= 1'b0;
        end else begin
            r_div    <= w_div_next;
            r_pix_en <= (w_div_next == DIV_W'(CLK_DIV - 1));
        end
    end

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .SYNC_START (H_VISIBLE + H_FP),
        .SYNC_LEN   (H_SYNC),
        .VIS        (H_VISIBLE),
        .POL        (SYNC_POL)
    ) u_h_axis (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (r_pix_en),
        .cnt   (w_hcnt),
        .wrap  (w_h_wrap),
        .sync  (w_h_sync),
        .vis   (w_h_vis)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .SYNC_START (V_VISIBLE + V_FP),
        .SYNC_LEN   (V_SYNC),
        .VIS        (V_VISIBLE),
        .POL        (SYNC_POL)
    ) u_v_axis (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_line_end),
        .cnt   (w_vcnt),
        .wrap  (w_v_wrap),
        .sync  (w_v_sync),
        .vis   (w_v_vis)
    );

    assign w_line_end = r_pix_en & w_h_wrap;
    // The edge leaving the last visible line is the only moment the shadow may change.
    assign w_capture  = w_line_end & (w_vcnt == 10'(V_VISIBLE - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_start <= 1'b0;
            r_upd_ack     <= 1'b0;
            r_ball        <= '{y: 10'd240, x: 10'd320};
            r_score       <= '0;
            r_ppos        <= '0;
        end else begin
            r_frame_start <= w_line_end & w_v_wrap;
            r_upd_ack     <= w_capture & bus.upd_valid;
            if (w_capture && bus.upd_valid) begin
                r_ball  <= bus.ball_in;
                r_score <= bus.score_in;
                r_ppos  <= bus.ppos_in;
            end
        end
    end

    assign bus.hcnt        = w_hcnt;
    assign bus.vcnt        = w_vcnt;
    assign bus.pix_en      = r_pix_en;
    assign bus.hsync       = w_h_sync;
    assign bus.vsync       = w_v_sync;
    assign bus.visible     = w_h_vis & w_v_vis;
    assign bus.frame_start = r_frame_start;
    assign bus.upd_ack     = r_upd_ack;
    assign bus.ball        = r_ball;
    assign bus.score       = r_score;
    assign bus.ppos        = r_ppos;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster; every clk is compared with a
// position-from-clock-count reference model, plus table vectors and corner sequences.
`timescale 1ns/1ps
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int HV = 16, HFP = 2, HS = 4, HBP = 3;
    localparam int HT = HV + HFP + HS + HBP;
    localparam int VV = 12, VFP = 2, VS = 2, VBP = 3;
    localparam int VT = VV + VFP + VS + VBP;
    localparam int FT = HT * VT;
    localparam int D  = 2;
    localparam logic POL  = 1'b0;
    localparam logic POL1 = 1'b1;
    localparam int RUN_LIMIT = 2 * FT * D + 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen_if bus ();
    vga_timing_gen_if bus1 ();

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .CLK_DIV(D), .SYNC_POL(POL)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .CLK_DIV(1), .SYNC_POL(POL1)
    ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int k = 0;
    logic   m_ack = 1'b0;
    ball_t  m_ball = '{y: 10'd240, x: 10'd320};
    score_t m_score = '0;
    ppos_t  m_ppos = '0;
    int ack_cnt = 0;
    int vis_acc = 0, hs_acc = 0, vs_acc = 0;
    int fs_q[$];
    int vis_q[$];
    int hs_q[$];
    int vs_q[$];

    typedef struct {
        logic [19:0] ball;
        logic [7:0]  score;
        logic [19:0] ppos;
        int          on_line;
        int          off_line;
        int          exp_acks;
    } vec_t;

    // Pixel advances seen after kk clk edges since reset release.
    function automatic int pcount(input int kk, input int d);
        if (kk == 0) return 0;
        return kk / d - ((d == 1) ? 1 : 0);
    endfunction

    function automatic logic win(input int x, input int lo, input int len);
        return (x >= lo) && (x < lo + len);
    endfunction

    function automatic logic exp_fs(input int kk, input int d);
        if (kk < 1) return 1'b0;
        return (pcount(kk, d) != pcount(kk - 1, d)) && (pcount(kk, d) % FT == 0);
    endfunction

    function automatic int mh();
        return (pcount(k, D) % FT) % HT;
    endfunction

    function automatic int mv();
        return (pcount(k, D) % FT) / HT;
    endfunction

    function automatic logic mpe();
        return (k >= 1) && (k % D == D - 1);
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    endtask

    task automatic check_cycle();
        int h, v, h1, v1;
        logic [83:0] g_vec, e_vec;
        h  = mh();
        v  = mv();
        h1 = (pcount(k, 1) % FT) % HT;
        v1 = (pcount(k, 1) % FT) / HT;
        e_vec = {10'(h), 10'(v), mpe(),
                 win(h, HV + HFP, HS) ? POL : ~POL,
                 win(v, VV + VFP, VS) ? POL : ~POL,
                 1'((h < HV) && (v < VV)), exp_fs(k, D), m_ack,
                 m_ball, m_score, m_ppos};
        g_vec = {bus.hcnt, bus.vcnt, bus.pix_en, bus.hsync, bus.vsync, bus.visible,
                 bus.frame_start, bus.upd_ack, bus.ball, bus.score, bus.ppos};
        chk("scan", 128'(g_vec), 128'(e_vec));
        e_vec = {10'(h1), 10'(v1), 1'(k >= 1),
                 win(h1, HV + HFP, HS) ? POL1 : ~POL1,
                 win(v1, VV + VFP, VS) ? POL1 : ~POL1,
                 1'((h1 < HV) && (v1 < VV)), exp_fs(k, 1), 1'b0,
                 10'd240, 10'd320, 8'h00, 20'h0};
        g_vec = {bus1.hcnt, bus1.vcnt, bus1.pix_en, bus1.hsync, bus1.vsync, bus1.visible,
                 bus1.frame_start, bus1.upd_ack, bus1.ball, bus1.score, bus1.ppos};
        chk("scan_div1", 128'(g_vec), 128'(e_vec));
    endtask

    task automatic observe();
        if (bus.frame_start) begin
            fs_q.push_back(cyc);
            vis_q.push_back(vis_acc);
            hs_q.push_back(hs_acc);
            vs_q.push_back(vs_acc);
            vis_acc = 0;
            hs_acc  = 0;
            vs_acc  = 0;
        end
        if (bus.pix_en) begin
            if (bus.visible) vis_acc++;
            if (bus.hsync == POL) hs_acc++;
            if (bus.vsync == POL) vs_acc++;
        end
        if (bus.upd_ack) begin
            ack_cnt++;
            $display("upd_ack: ball=%05h score=%02h ppos=%05h cycle %0d",
                     bus.ball, bus.score, bus.ppos, cyc);
        end
    endtask

    // One clk: sample driven inputs, advance the model across the edge, compare.
    task automatic step();
        logic v_s, r_s;
        ball_t b_s;
        score_t s_s;
        ppos_t p_s;
        int n0, n1;
        v_s = bus.upd_valid;
        b_s = bus.ball_in;
        s_s = bus.score_in;
        p_s = bus.ppos_in;
        r_s = rst_n;
        @(posedge clk);
        if (!r_s) begin
            k = 0;
            m_ack = 1'b0;
            m_ball = '{y: 10'd240, x: 10'd320};
            m_score = '0;
            m_ppos = '0;
        end else begin
            k++;
            n0 = pcount(k - 1, D);
            n1 = pcount(k, D);
            m_ack = (n0 != n1) && (n1 % FT == VV * HT) && v_s;
            if (m_ack) begin
                m_ball = b_s;
                m_score = s_s;
                m_ppos = p_s;
            end
        end
        @(negedge clk);
        cyc++;
        check_cycle();
        observe();
    endtask

    task automatic run_to(input int h, input int v);
        int guard;
        guard = 0;
        while (!(mh() == h && mv() == v && mpe()) && guard < RUN_LIMIT) begin
            step();
            guard++;
        end
        chk("run_to", 128'({bus.hcnt, bus.vcnt}), 128'({10'(h), 10'(v)}));
    endtask

    initial begin
        vec_t tbl[6];
        int a0, hs_clk, hmin, hmax, vmin, vmax, fs_before, guard;
        logic got_ack;
        logic [47:0] prev_sh;

        tbl[0] = '{20'h1E0A0, 8'h37, 20'h12345, 3,  VT, 1};
        tbl[1] = '{20'h0ABCD, 8'h99, 20'h00FFF, 3,  8,  0};
        tbl[2] = '{20'h2F00F, 8'h42, 20'h0A0B0, 11, VT, 1};
        tbl[3] = '{20'h11111, 8'h55, 20'h22222, 2,  11, 0};
        tbl[4] = '{20'h3FFFF, 8'h08, 20'hFFFFF, 2,  12, 1};
        tbl[5] = '{20'h00001, 8'h10, 20'h00002, 13, VT, 0};

        bus.upd_valid = 1'b0;  bus.ball_in = '0;  bus.score_in = '0;  bus.ppos_in = '0;
        bus1.upd_valid = 1'b0; bus1.ball_in = '0; bus1.score_in = '0; bus1.ppos_in = '0;
        rst_n = 1'b0;
        repeat (3) step();
        chk("reset_state",
            128'({bus.hcnt, bus.vcnt, bus.pix_en, bus.hsync, bus.vsync, bus.visible,
                  bus.frame_start, bus.upd_ack, bus.ball, bus.score, bus.ppos}),
            128'({10'd0, 10'd0, 1'b0, ~POL, ~POL, 1'b1, 1'b0, 1'b0,
                  10'd240, 10'd320, 8'h00, 20'h0}));

        rst_n = 1'b1;
        step();
        chk("first_pix", 128'({bus.hcnt, bus.pix_en}), 128'({10'd0, 1'b1}));
        step();
        chk("second_pix", 128'({bus.hcnt, bus.pix_en}), 128'({10'd1, 1'b0}));

        // Three full frames: spacing, pulse count, visible and sync pixel counts.
        fs_q.delete(); vis_q.delete(); hs_q.delete(); vs_q.delete();
        guard = 0;
        while (fs_q.size() < 4 && guard < 5 * FT * D) begin
            step();
            guard++;
        end
        chk("fs_count", 128'(fs_q.size()), 128'(4));
        for (int i = 1; i < 4 && i < fs_q.size(); i++) begin
            chk("fs_spacing", 128'(fs_q[i] - fs_q[i-1]), 128'(FT * D));
            chk("vis_pixels", 128'(vis_q[i]), 128'(HV * VV));
            chk("hs_pixels", 128'(hs_q[i]), 128'(HS * VT));
            chk("vs_pixels", 128'(vs_q[i]), 128'(VS * HT));
        end

        // Sync windows over one frame.
        run_to(0, 0);
        hs_clk = 0; hmin = 9999; hmax = -1; vmin = 9999; vmax = -1;
        for (int c = 0; c < FT * D; c++) begin
            step();
            if (bus.hsync == POL) begin
                hs_clk++;
                if (int'(bus.hcnt) < hmin) hmin = int'(bus.hcnt);
                if (int'(bus.hcnt) > hmax) hmax = int'(bus.hcnt);
            end
            if (bus.vsync == POL) begin
                if (int'(bus.vcnt) < vmin) vmin = int'(bus.vcnt);
                if (int'(bus.vcnt) > vmax) vmax = int'(bus.vcnt);
            end
        end
        chk("hsync_clks", 128'(hs_clk), 128'(HS * D * VT));
        chk("hsync_first", 128'(hmin), 128'(HV + HFP));
        chk("hsync_last", 128'(hmax), 128'(HV + HFP + HS - 1));
        chk("vsync_first", 128'(vmin), 128'(VV + VFP));
        chk("vsync_last", 128'(vmax), 128'(VV + VFP + VS - 1));

        // Update-offer table, one frame per vector.
        prev_sh = '0;
        for (int i = 0; i < 6; i++) begin
            run_to(0, 0);
            bus.ball_in  = tbl[i].ball;
            bus.score_in = tbl[i].score;
            bus.ppos_in  = tbl[i].ppos;
            a0 = ack_cnt;
            got_ack = 1'b0;
            for (int c = 0; c < FT * D; c++) begin
                bus.upd_valid = (mv() >= tbl[i].on_line) && (mv() < tbl[i].off_line) && !got_ack;
                step();
                if (bus.upd_ack) got_ack = 1'b1;
            end
            bus.upd_valid = 1'b0;
            chk("vec_acks", 128'(ack_cnt - a0), 128'(tbl[i].exp_acks));
            if (tbl[i].exp_acks != 0) prev_sh = {tbl[i].ball, tbl[i].score, tbl[i].ppos};
            chk("vec_shadow", 128'({bus.ball, bus.score, bus.ppos}), 128'(prev_sh));
            $display("vector %0d: valid lines %0d..%0d acks=%0d shadow=%012h",
                     i, tbl[i].on_line, tbl[i].off_line - 1, ack_cnt - a0,
                     {bus.ball, bus.score, bus.ppos});
        end

        // Offer held across three frames: exactly one ack per frame.
        run_to(0, 0);
        bus.ball_in = 20'h0F0F0; bus.score_in = 8'h21; bus.ppos_in = 20'h05050;
        bus.upd_valid = 1'b1;
        a0 = ack_cnt;
        for (int c = 0; c < 3 * FT * D; c++) step();
        bus.upd_valid = 1'b0;
        chk("held_acks", 128'(ack_cnt - a0), 128'(3));

        // Mid-frame reset for a single clk.
        run_to(10, 7);
        rst_n = 1'b0;
        step();
        chk("mid_reset",
            128'({bus.hcnt, bus.vcnt, bus.pix_en, bus.hsync, bus.vsync, bus.visible,
                  bus.frame_start, bus.upd_ack, bus.ball, bus.score, bus.ppos}),
            128'({10'd0, 10'd0, 1'b0, ~POL, ~POL, 1'b1, 1'b0, 1'b0,
                  10'd240, 10'd320, 8'h00, 20'h0}));
        rst_n = 1'b1;
        fs_before = fs_q.size();
        for (int c = 0; c < 2 * HT * D; c++) step();
        chk("no_fs_after_reset", 128'(fs_q.size()), 128'(fs_before));
        chk("restart_pos", 128'({bus.hcnt, bus.vcnt}), 128'({10'd0, 10'd2}));

        // Random offers, data and occasional resets against the model.
        for (int s = 0; s < 40; s++) begin
            int len;
            len = int'($urandom_range(4, 400));
            bus.ball_in   = 20'($urandom);
            bus.score_in  = 8'($urandom);
            bus.ppos_in   = 20'($urandom);
            bus.upd_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            for (int c = 0; c < len; c++) begin
                step();
                if (bus.upd_ack) bus.upd_valid = 1'b0;
            end
        end
        bus.upd_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
